// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Time-multiplexed scan controller for a six-digit, seven-segment display.
//   Each frame latches the six BCD digits and the blink mask in a one-cycle
//   LOAD state. It then drives the digits 0..5 one at a time. Each digit is
//   shown for DWELL cycles, and BLANK guard cycles follow it with all anodes off.
//   A frame-rate blink and a timed error pattern (dashes) are layered on top.
//
// Parameters
//   DWELL        cycles each digit is driven              (1..255)
//   BLANK        all-off guard cycles after each digit    (1..255)
//   BLINK_FRAMES frames per blink half-period             (1..255)
//   ERR_FRAMES   frames the dash pattern is held          (1..255)
//
// Ports
//   CLK          clock, rising edge
//   rst_n        synchronous active-low reset
//   en_disp      display enable (level)
//   err_disp     error request, single-cycle pulse
//   sec_l..hour_m BCD digits 0..5
//   blink_mask   bit i enables blinking of digit i
//   an           one-hot active-high digit select (registered)
//   seg          active-high segments {g,f,e,d,c,b,a} (registered)
//   frame_start  one-cycle pulse during each LOAD cycle (registered)
module disp_scan_ctrl #(
  parameter int unsigned DWELL        = 4,
  parameter int unsigned BLANK        = 1,
  parameter int unsigned BLINK_FRAMES = 50,
  parameter int unsigned ERR_FRAMES   = 100
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       en_disp,
  input  logic       err_disp,
  input  logic [3:0] sec_l,
  input  logic [3:0] sec_m,
  input  logic [3:0] min_l,
  input  logic [3:0] min_m,
  input  logic [3:0] hour_l,
  input  logic [3:0] hour_m,
  input  logic [5:0] blink_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_M1 = 8'(BLANK - 1);
  localparam logic [7:0] BLINK_M1 = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] ERR_LOAD = 8'(ERR_FRAMES);
  localparam logic [2:0] LAST_IDX = 3'd5;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, GUARD} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      slot_cnt_q, slot_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [5:0][3:0] snap_q, snap_d;
  logic [5:0]      mask_q, mask_d;
  // Per-frame copies of the blink phase and error status, taken at LOAD, so
  // that the whole frame is shown consistently even though the live counters
  // are updated on the edge that leaves LOAD.
  logic            blink_frame_q, blink_frame_d;
  logic            err_frame_q, err_frame_d;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            fs_q, fs_d;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Next-state and counter logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_cnt_d    = slot_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    err_cnt_d     = err_cnt_q;
    snap_d        = snap_q;
    mask_d        = mask_q;
    blink_frame_d = blink_frame_q;
    err_frame_d   = err_frame_q;

    case (state_q)
      IDLE: begin
        idx_d      = '0;
        slot_cnt_d = '0;
        if (en_disp) state_d = LOAD;
      end
      LOAD: begin
        snap_d        = {hour_m, hour_l, min_m, min_l, sec_m, sec_l};
        mask_d        = blink_mask;
        idx_d         = '0;
        slot_cnt_d    = '0;
        blink_frame_d = blink_phase_q;
        err_frame_d   = (err_cnt_q != '0);
        if (frame_cnt_q == BLINK_M1) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (err_cnt_q != '0) err_cnt_d = err_cnt_q - 8'd1;
        state_d = SCAN;
      end
      SCAN: begin
        if (slot_cnt_q == DWELL_M1) begin
          slot_cnt_d = '0;
          state_d    = GUARD;
        end else begin
          slot_cnt_d = slot_cnt_q + 8'd1;
        end
      end
      GUARD: begin
        if (slot_cnt_q == BLANK_M1) begin
          slot_cnt_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = SCAN;
          end else begin
            state_d = LOAD;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en_disp) state_d = IDLE;
    // A fresh error request wins over the LOAD decrement in the same cycle.
    if (err_disp) err_cnt_d = ERR_LOAD;
  end

  // Output values are derived from the *next* state so that the registered
  // outputs change on the same edge on which the FSM enters that state.
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    fs_d  = (state_d == LOAD);
    if (state_d == SCAN) begin
      if (err_frame_d) begin
        an_d  = 6'(1) << idx_d;
        seg_d = SEG_DASH;
      end else if (!(blink_frame_d && mask_d[idx_d])) begin
        an_d  = 6'(1) << idx_d;
        seg_d = bcd_to_seg(snap_d[idx_d]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      slot_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      err_cnt_q     <= '0;
      snap_q        <= '0;
      mask_q        <= '0;
      blink_frame_q <= 1'b0;
      err_frame_q   <= 1'b0;
      an_q          <= '0;
      seg_q         <= '0;
      fs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_cnt_q    <= slot_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      err_cnt_q     <= err_cnt_d;
      snap_q        <= snap_d;
      mask_q        <= mask_d;
      blink_frame_q <= blink_frame_d;
      err_frame_q   <= err_frame_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      fs_q          <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

  an_onehot0: assert property (@(posedge CLK) $onehot0(an_q));

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
//   Self-checking bench for disp_scan_ctrl at default parameters. Expected
//   outputs for every cycle are derived from the frame position and pushed
//   to a queue. They are popped and compared half a cycle after each edge.
module tb_disp_scan_ctrl;

  localparam int DW = 4;
  localparam int BL = 1;
  localparam int FL = 1 + 6 * (DW + BL);

  logic       CLK = 1'b0;
  logic       rst_n, en_disp, err_disp;
  logic [3:0] sec_l, sec_m, min_l, min_m, hour_l, hour_m;
  logic [5:0] blink_mask;
  logic [5:0] an;
  logic [6:0] seg;
  logic       frame_start;

  always #5 CLK = ~CLK;

  disp_scan_ctrl #(
    .DWELL(DW),
    .BLANK(BL),
    .BLINK_FRAMES(50),
    .ERR_FRAMES(100)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .en_disp(en_disp),
    .err_disp(err_disp),
    .sec_l(sec_l),
    .sec_m(sec_m),
    .min_l(min_l),
    .min_m(min_m),
    .hour_l(hour_l),
    .hour_m(hour_m),
    .blink_mask(blink_mask),
    .an(an),
    .seg(seg),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fs;
  } obs_t;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  obs_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  dec_vec_t    tv[16];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [41:0] pack_segs(input logic [3:0] d0, d1, d2, d3, d4, d5);
    return {seg_of(d5), seg_of(d4), seg_of(d3), seg_of(d2), seg_of(d1), seg_of(d0)};
  endfunction

  function automatic logic [5:0] dark_for(input int f, input logic [5:0] m);
    return (((f / 50) % 2) == 1) ? m : 6'b0;
  endfunction

  // Expected outputs at position p of a frame (p=0 is the LOAD cycle).
  function automatic obs_t exp_at(input int p, input logic [41:0] segs,
                                  input logic [5:0] dark, input logic err);
    obs_t o;
    int k, d, w;
    o = '0;
    if (p == 0) begin
      o.fs = 1'b1;
      return o;
    end
    k = p - 1;
    d = k / (DW + BL);
    w = k % (DW + BL);
    if (w < DW && (err || !dark[d])) begin
      o.an  = 6'(1) << d;
      o.seg = err ? 7'h40 : segs[7*d +: 7];
    end
    return o;
  endfunction

  task automatic cycle_check(input obs_t e, input string name);
    obs_t got, want;
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    want = exp_q.pop_front();
    got  = {an, seg, frame_start};
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got an=%b seg=%h fs=%b, required an=%b seg=%h fs=%b",
                  name, got.an, got.seg, got.fs, want.an, want.seg, want.fs);
  endtask

  task automatic frame_part(input logic [41:0] segs, input logic [5:0] dark,
                            input logic err, input int from, input int to,
                            input string name);
    for (int p = from; p <= to; p++) cycle_check(exp_at(p, segs, dark, err), name);
  endtask

  initial begin
    logic [41:0] s_norm, s_seven;
    int f;

    tv[0]  = '{4'h0, 7'h3F};  tv[1]  = '{4'h1, 7'h06};
    tv[2]  = '{4'h2, 7'h5B};  tv[3]  = '{4'h3, 7'h4F};
    tv[4]  = '{4'h4, 7'h66};  tv[5]  = '{4'h5, 7'h6D};
    tv[6]  = '{4'h6, 7'h7D};  tv[7]  = '{4'h7, 7'h07};
    tv[8]  = '{4'h8, 7'h7F};  tv[9]  = '{4'h9, 7'h6F};
    tv[10] = '{4'hA, 7'h00};  tv[11] = '{4'hB, 7'h00};
    tv[12] = '{4'hC, 7'h00};  tv[13] = '{4'hD, 7'h00};
    tv[14] = '{4'hE, 7'h00};  tv[15] = '{4'hF, 7'h00};

    s_norm  = pack_segs(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    s_seven = pack_segs(4'd7, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    // Reset held with enable and error request active: reset wins.
    rst_n = 1'b0; en_disp = 1'b1; err_disp = 1'b1; blink_mask = '0;
    sec_l = 4'd1; sec_m = 4'd2; min_l = 4'd3; min_m = 4'd4; hour_l = 4'd5; hour_m = 4'd6;
    repeat (3) cycle_check('0, "reset");
    err_disp = 1'b0;
    rst_n    = 1'b1;

    // Frame 0: basic scan; frame 1: live change mid-frame; frame 2: new value.
    frame_part(s_norm, '0, 1'b0, 0, FL - 1, "frame0");
    frame_part(s_norm, '0, 1'b0, 0, 17, "frame1_pre");
    sec_l = 4'd7;
    frame_part(s_norm, '0, 1'b0, 18, FL - 1, "frame1_frozen");
    frame_part(s_seven, '0, 1'b0, 0, FL - 1, "frame2_updated");
    f = 3;

    // Decode table on digit 0, one frame per code.
    for (int i = 0; i < 16; i++) begin
      sec_l = tv[i].code;
      frame_part({s_norm[41:7], tv[i].seg}, '0, 1'b0, 0, FL - 1, "decode");
      f++;
    end
    sec_l = 4'd1;

    // Blink digits 0 and 1.
    blink_mask = 6'b000011;
    while (f < 152) begin
      frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 0, FL - 1, "blink");
      f++;
    end

    // Error: pulse mid-frame 152; frame 152 itself is still normal.
    blink_mask = 6'b000000;
    frame_part(s_norm, '0, 1'b0, 0, 10, "err_pre");
    err_disp = 1'b1;
    frame_part(s_norm, '0, 1'b0, 11, 11, "err_pre");
    err_disp = 1'b0;
    frame_part(s_norm, '0, 1'b0, 12, FL - 1, "err_pre");
    f++;
    blink_mask = 6'b111111;  // dashes must override blinking
    while (f < 213) begin
      frame_part(s_norm, dark_for(f, blink_mask), 1'b1, 0, FL - 1, "err_dash");
      f++;
    end
    // Second pulse 60 frames into the error: reload, no accumulation.
    frame_part(s_norm, '0, 1'b1, 0, 10, "err_dash");
    err_disp = 1'b1;
    frame_part(s_norm, '0, 1'b1, 11, 11, "err_dash");
    err_disp = 1'b0;
    frame_part(s_norm, '0, 1'b1, 12, FL - 1, "err_dash");
    f++;
    while (f < 313) begin
      frame_part(s_norm, dark_for(f, blink_mask), 1'b1, 0, FL - 1, "err_reload");
      f++;
    end
    // Frame 313 is the last one of the reloaded error; a pulse in its LOAD
    // cycle must win over the decrement to zero.
    frame_part(s_norm, '0, 1'b1, 0, 0, "err_load_pulse");
    err_disp = 1'b1;
    frame_part(s_norm, '0, 1'b1, 1, 1, "err_load_pulse");
    err_disp = 1'b0;
    frame_part(s_norm, '0, 1'b1, 2, FL - 1, "err_load_pulse");
    f++;
    while (f < 414) begin
      frame_part(s_norm, dark_for(f, blink_mask), 1'b1, 0, FL - 1, "err_after_load");
      f++;
    end
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 0, FL - 1, "err_expired");
    f++;

    // Enable dropped during digit 2 SCAN.
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 0, 12, "en_pre");
    f++;
    en_disp = 1'b0;
    cycle_check('0, "en_drop");
    repeat (3) cycle_check('0, "idle");
    en_disp = 1'b1;
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 0, FL - 1, "reenable");
    f++;

    // Reset for one cycle in a GUARD cycle while an error is pending.
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 0, 0, "rst_pre");
    err_disp = 1'b1;
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 1, 1, "rst_pre");
    err_disp = 1'b0;
    frame_part(s_norm, dark_for(f, blink_mask), 1'b0, 2, FL - 1, "rst_pre");
    frame_part(s_norm, '0, 1'b1, 0, 5, "rst_err_frame");
    rst_n = 1'b0;
    cycle_check('0, "reset_mid_guard");
    rst_n = 1'b1;
    frame_part(s_norm, dark_for(0, blink_mask), 1'b0, 0, FL - 1, "post_reset");
    frame_part(s_norm, dark_for(1, blink_mask), 1'b0, 0, FL - 1, "post_reset2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
